// File: rtl/uart_tx_8n1_if.sv
// Byte-source / serial-line bundle for uart_tx_8n1.
// Signal names are written from the transmitter's point of view.
//   i_enable   : level, start a frame whenever the transmitter is free
//   i_data     : byte offered by the provider, sampled only while o_get_next is high
//   o_get_next : one-cycle advance strobe back to the provider
//   o_tx       : serial line, idle high
//   o_busy     : high from the start bit through the stop bit
// Modports: slave = transmitter, master = byte provider / line observer.
interface uart_tx_8n1_if;
    logic       i_enable;
    logic [7:0] i_data;
    logic       o_get_next;
    logic       o_tx;
    logic       o_busy;

    modport master (
        output i_enable,
        output i_data,
        input  o_get_next,
        input  o_tx,
        input  o_busy
    );

    modport slave (
        input  i_enable,
        input  i_data,
        output o_get_next,
        output o_tx,
        output o_busy
    );
endinterface

// File: rtl/uart_tx_8n1.sv
// Serial 8N1 transmitter that drains a byte provider.
// While enabled it latches the provider's current byte, strobes o_get_next to advance it,
// and shifts the byte out LSB-first. Frames chain back to back with no idle cycle.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_src  : uart_tx_8n1_if.slave (i_enable, i_data, o_get_next, o_tx, o_busy)
// Parameters:
//   CLOCKS_PER_BAUD : clock cycles per bit period, 2..65535
// Build option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is sent between the data bits and
//                       the stop bit (11 bit periods per frame); otherwise plain 8N1.
module uart_tx_8n1 #(
    parameter int unsigned CLOCKS_PER_BAUD = 104
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    uart_tx_8n1_if.slave io_src
);

    localparam int unsigned CntW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic w_baud_end;
    logic w_load;

    assign w_baud_end = (r_baud_cnt == BaudLast);

    // Latch points: any idle cycle, or the last stop-bit cycle when chaining.
    // Gated by reset so the provider is never advanced while the block is held in reset.
    assign w_load = i_rst_n & io_src.i_enable &
                    ((r_state == StIdle) | ((r_state == StStop) & w_baud_end));

    assign io_src.o_get_next = w_load;
    assign io_src.o_tx       = r_tx;
    assign io_src.o_busy     = r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + 1'b1;

            case (r_state)
                StIdle: begin
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                end
                StStart: begin
                    if (w_baud_end) begin
                        r_state   <= StData;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                StData: begin
                    if (w_baud_end) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= StParity;
                            r_tx    <= r_parity;
`else
                            r_state <= StStop;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // Next bit is bit 1 of the pre-shift register.
                            r_tx <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (w_baud_end) begin
                        r_state <= StStop;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (w_baud_end) begin
                        r_state <= StIdle;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            // A load overrides whatever the state above decided: start bit goes out next cycle.
            if (w_load) begin
                r_shift    <= io_src.i_data;
                r_state    <= StStart;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parity   <= ^io_src.i_data;
`endif
            end
        end
    end

endmodule

// File: doc/uart_tx_8n1.md
# uart_tx_8n1

Serial transmitter that drains a byte source and drives an asynchronous UART line. It sits directly downstream of the byte-sequence provider. While enabled, it takes the current byte from that provider, pulses `o_get_next` to advance it, and shifts the byte out LSB-first as an 8N1 frame. Back-to-back frames are sent with no idle gap, so a continuous message is emitted as long as `i_enable` stays high.

## Interface
- `CLOCKS_PER_BAUD`, default 104: clock cycles per bit period (12 MHz / 115200). Legal range is 2 to 65535.
- `i_clk`  input  1  system clock; all state changes on the rising edge.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_enable`  input  1  level; while high, the block starts a new frame whenever it is free.
- `i_data`  input  8  byte to send; sampled only in the cycle `o_get_next` is high.
- `o_get_next`  output  1  one-cycle pulse in the cycle `i_data` is latched; drives the provider's advance input.
- `o_tx`  output  1  serial line; idle high.
- `o_busy`  output  1  high while a frame is in progress (START through STOP).

## Operation
- States: IDLE, START, DATA, (PARITY), STOP.
- Counters:
  - Baud counter: width `$clog2(CLOCKS_PER_BAUD)`. It counts 0 to `CLOCKS_PER_BAUD`-1, then wraps to 0 and ends the bit period.
  - Bit index: 3 bits.
- IDLE:
  - `o_tx`=1, `o_busy`=0.
  - If `i_enable`=1: latch `i_data` into the shift register, assert `o_get_next`, and go to START with the baud counter at 0.
- START: `o_tx`=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - `o_tx` = shift register bit 0.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit 7 completes, go to PARITY if compiled in, otherwise to STOP.
- STOP: `o_tx`=1 for one bit period. In its final cycle (baud counter = `CLOCKS_PER_BAUD`-1):
  - If `i_enable`=1: latch `i_data`, assert `o_get_next`, and go to START. There is no IDLE cycle between frames.
  - Otherwise: go to IDLE.
- `o_get_next` is high for exactly one cycle per frame, and never outside the two latch points above.
- Deasserting `i_enable` mid-frame does not abort the frame. The current frame completes and no new frame starts.
- `i_data` changes while not latching are ignored. The shift register holds the frame byte.
- Reset is asynchronous and may arrive mid-frame:
  - State returns to IDLE immediately and the frame is abandoned.
  - Outputs take their reset values immediately: `o_tx`=1, `o_busy`=0, `o_get_next`=0.
  - Counters and shift register reset to 0.

## Timing
- Latency from `o_get_next` to the `o_tx` falling edge (start bit): 1 cycle. `o_tx` is registered.
- Frame length is 10×`CLOCKS_PER_BAUD` cycles, or 11× with parity.
- In continuous mode, `o_get_next` pulses are exactly one frame length apart.
- Each bit on `o_tx` is stable for exactly `CLOCKS_PER_BAUD` cycles. There are no glitches between bits.
- `o_busy` rises with the start bit and falls one cycle after the last stop-bit cycle, but only when not chaining. In continuous mode it stays high.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: a PARITY state is inserted between DATA and STOP. `o_tx` carries the even-parity bit (XOR of the 8 data bits) for one bit period. The frame is 11 bit periods.
  - Undefined: no PARITY state, 8N1 framing, 10 bit periods. No parity logic is synthesized.

## Test plan
Benches use `CLOCKS_PER_BAUD`=4.
- Single byte: `i_data`=0x48, pulse `i_enable` for 1 cycle.
  - One `o_get_next` pulse.
  - `o_tx` carries 0,0,0,0,1,0,0,1,0,1 (start, LSB-first data, stop), 4 cycles each.
  - `o_busy` is high for 40 cycles.
- Continuous: `i_enable` held high, provider driven by `o_get_next`.
  - Emits "Hello, world! " repeatedly.
  - `o_get_next` pulses are 40 cycles apart.
  - `o_tx` never idles between frames.
- Mid-frame disable: drop `i_enable` during DATA.
  - The current frame completes.
  - `o_tx` then stays 1, `o_busy`=0, and no further `o_get_next` pulse occurs.
- Reset mid-frame: assert `i_rst_n`=0 during bit 3.
  - Without waiting for a clock edge, `o_tx`=1 and `o_busy`=0.
  - After release with `i_enable`=1, a fresh full frame is sent.
- Input stability: change `i_data` every cycle during a frame. The transmitted byte equals the value latched with `o_get_next`.
- With `UART_TX_PARITY_EN`:
  - 0x48 produces parity bit 0; 0x49 produces parity bit 1.
  - Frame is 44 cycles and `o_get_next` spacing is 44 cycles.
